draw_player_sprite: RTL and testbench



---
 rtl/draw_player_sprite_if.sv | 18 +
 rtl/draw_player_sprite.sv | 205 ++++++++++++++++++++
 tb/tb_draw_player_sprite.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_player_sprite_if.sv
// vga_if: VGA pixel bundle passed between overlay stages.
//   hcount, vcount : current pixel coordinates
//   hsync, vsync   : sync pulses
//   hblnk, vblnk   : blanking flags
//   rgb            : 12-bit colour (4 bits per channel, R in [11:8])
// Modports: vga_in (consumer view) and vga_out (producer view).
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_player_sprite.sv
// draw_player_sprite: overlays a ROM-backed player sprite on the VGA stream.
// A colour key makes pixels transparent. A hit starts a timed flash that
// tints the sprite and can optionally blink it.
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   xpos, ypos   sprite top-left corner, latched on the vsync rising edge
//   mirror       horizontal flip, latched on the vsync rising edge
//   hit          hit request; a rising edge starts a flash
//   rgb_sprite   ROM word for the current sprite_addr (ready for stage 2)
//   sprite_addr  registered ROM address
//   flash_active high while the flash sequence runs
//   vga_in       upstream pixel bundle
//   vga_out      downstream pixel bundle, two cycles behind vga_in
module draw_player_sprite #(
    parameter int          SPR_W       = 157,
    parameter int          SPR_H       = 99,
    parameter int          ADDR_W      = 14,
    parameter logic [11:0] KEY_COLOR   = 12'h0F0,
    parameter logic [11:0] TINT        = 12'hA00,
    parameter int          FLASH_TICKS = 32_500_000,
    parameter int          BLINK_TICKS = 4_062_500
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    input  logic              mirror,
    input  logic              hit,
    input  logic [11:0]       rgb_sprite,
    output logic [ADDR_W-1:0] sprite_addr,
    output logic              flash_active,
    vga_if.vga_in             vga_in,
    vga_if.vga_out            vga_out
);

    localparam int CNT_W = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    localparam int BL_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(FLASH_TICKS - 1);
    localparam logic [BL_W-1:0]   BLINK_LAST = BL_W'((BLINK_TICKS > 0) ? BLINK_TICKS - 1 : 0);
    localparam logic [11:0]       SPR_W12    = 12'(SPR_W);
    localparam logic [11:0]       SPR_H12    = 12'(SPR_H);
    localparam logic [7:0]        COL_LAST   = 8'(SPR_W - 1);
    localparam logic [ADDR_W-1:0] SPR_W_A    = ADDR_W'(SPR_W);

    typedef enum logic {IDLE, FLASH} state_t;

    // Frame-latched placement
    logic [10:0] pos_x_reg, pos_y_reg;
    logic        mir_reg;

    // Stage-1 registers
    logic [10:0] hcount_d1_reg, vcount_d1_reg;
    logic        hsync_d1_reg, vsync_d1_reg, hblnk_d1_reg, vblnk_d1_reg;
    logic [11:0] rgb_d1_reg;
    logic        inside_d1_reg;

    // Flash FSM state
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [BL_W-1:0]  blink_cnt_reg;
    logic             vis_reg;
    logic             hit_q_reg;

    // ---------------- Stage-1 combinational ----------------
    logic [11:0]       hc12, vc12, x_end, y_end;
    logic              inside_next;
    logic [7:0]        rel_x, rel_y, col;
    logic [ADDR_W-1:0] addr_next;
    logic              vsync_rise;

    always_comb begin
        hc12  = {1'b0, vga_in.hcount};
        vc12  = {1'b0, vga_in.vcount};
        // 12-bit end bounds keep a sprite near x/y = 2047 from wrapping to 0
        x_end = {1'b0, pos_x_reg} + SPR_W12;
        y_end = {1'b0, pos_y_reg} + SPR_H12;
        inside_next = (hc12 >= {1'b0, pos_x_reg}) && (hc12 < x_end) &&
                      (vc12 >= {1'b0, pos_y_reg}) && (vc12 < y_end) &&
                      !vga_in.hblnk && !vga_in.vblnk;
        rel_x = 8'(vga_in.hcount - pos_x_reg);
        rel_y = 8'(vga_in.vcount - pos_y_reg);
        col   = mir_reg ? (COL_LAST - rel_x) : rel_x;
        addr_next  = ADDR_W'(rel_y) * SPR_W_A + ADDR_W'(col);
        // vsync_d1_reg is the previous vsync sample, so it doubles as the edge detector
        vsync_rise = vga_in.vsync && !vsync_d1_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_reg     <= '0;
            pos_y_reg     <= '0;
            mir_reg       <= 1'b0;
            hcount_d1_reg <= '0;
            vcount_d1_reg <= '0;
            hsync_d1_reg  <= 1'b0;
            vsync_d1_reg  <= 1'b0;
            hblnk_d1_reg  <= 1'b0;
            vblnk_d1_reg  <= 1'b0;
            rgb_d1_reg    <= '0;
            inside_d1_reg <= 1'b0;
            sprite_addr   <= '0;
        end else begin
            if (vsync_rise) begin
                pos_x_reg <= xpos;
                pos_y_reg <= ypos;
                mir_reg   <= mirror;
            end
            hcount_d1_reg <= vga_in.hcount;
            vcount_d1_reg <= vga_in.vcount;
            hsync_d1_reg  <= vga_in.hsync;
            vsync_d1_reg  <= vga_in.vsync;
            hblnk_d1_reg  <= vga_in.hblnk;
            vblnk_d1_reg  <= vga_in.vblnk;
            rgb_d1_reg    <= vga_in.rgb;
            inside_d1_reg <= inside_next;
            // Address holds outside the box so the ROM output stays quiet
            if (inside_next)
                sprite_addr <= addr_next;
        end
    end

    // ---------------- Stage-2 combinational ----------------
    logic [11:0] tinted;
    logic [11:0] rgb_next;
    logic        hidden;

    // Per-channel saturating add; each channel is isolated so no carry crosses
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tint
            logic [4:0] sum;
            assign sum = {1'b0, rgb_sprite[4*gi +: 4]} + {1'b0, TINT[4*gi +: 4]};
            assign tinted[4*gi +: 4] = sum[4] ? 4'hF : sum[3:0];
        end
    endgenerate

    always_comb begin
        hidden   = flash_active && !vis_reg;
        rgb_next = rgb_d1_reg;
        if (inside_d1_reg && (rgb_sprite != KEY_COLOR) && !hidden)
            rgb_next = flash_active ? tinted : rgb_sprite;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.hcount <= hcount_d1_reg;
            vga_out.vcount <= vcount_d1_reg;
            vga_out.hsync  <= hsync_d1_reg;
            vga_out.vsync  <= vsync_d1_reg;
            vga_out.hblnk  <= hblnk_d1_reg;
            vga_out.vblnk  <= vblnk_d1_reg;
            vga_out.rgb    <= rgb_next;
        end
    end

    // ---------------- Flash FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            blink_cnt_reg <= '0;
            vis_reg       <= 1'b1;
            hit_q_reg     <= 1'b0;
            flash_active  <= 1'b0;
        end else begin
            hit_q_reg <= hit;
            if (state_reg == IDLE) begin
                if (hit && !hit_q_reg) begin
                    state_reg     <= FLASH;
                    flash_active  <= 1'b1;
                    cnt_reg       <= '0;
                    blink_cnt_reg <= '0;
                    vis_reg       <= 1'b1;
                end
            end else begin
                // Hit edges are ignored here: no retrigger, no extension
                if (cnt_reg == CNT_LAST) begin
                    state_reg    <= IDLE;
                    flash_active <= 1'b0;
                    cnt_reg      <= '0;
                    vis_reg      <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (BLINK_TICKS > 0) begin
                        if (blink_cnt_reg == BLINK_LAST) begin
                            blink_cnt_reg <= '0;
                            vis_reg       <= !vis_reg;
                        end else begin
                            blink_cnt_reg <= blink_cnt_reg + BL_W'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_draw_player_sprite.sv
// Self-checking bench for draw_player_sprite with a small 4x2 sprite.
module tb_draw_player_sprite;

    localparam int          SPR_W  = 4;
    localparam int          SPR_H  = 2;
    localparam int          ADDR_W = 3;
    localparam int          FT     = 12;
    localparam int          BT     = 3;
    localparam logic [11:0] KEY    = 12'h0F0;
    localparam logic [11:0] TINT   = 12'hA00;
    localparam int          HN     = 4200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [10:0]       xpos, ypos;
    logic              mirror, hit;
    logic [11:0]       rgb_sprite;
    logic [ADDR_W-1:0] sprite_addr;
    logic              flash_active;

    vga_if u_in ();
    vga_if u_out ();

    logic [11:0] rom [0:7];
    // ROM word for the presented address, consumed by the DUT's output stage
    assign rgb_sprite = rom[sprite_addr];

    draw_player_sprite #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .KEY_COLOR(KEY),
        .TINT(TINT), .FLASH_TICKS(FT), .BLINK_TICKS(BT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .xpos(xpos), .ypos(ypos), .mirror(mirror),
        .hit(hit), .rgb_sprite(rgb_sprite), .sprite_addr(sprite_addr),
        .flash_active(flash_active), .vga_in(u_in), .vga_out(u_out)
    );

    int n_chk = 0;
    int n_fail = 0;

    // History indexed by step+2; indices 0,1 stand for the all-zero reset state
    logic [25:0] tim_a [0:HN-1];
    logic [11:0] bg_a  [0:HN-1];
    bit          ins_a [0:HN-1];
    int          addr_a[0:HN-1];
    bit          hit_a [0:HN-1];
    bit          vs_a  [0:HN-1];
    bit          fa_a  [0:HN-1];
    bit          hid_a [0:HN-1];

    int n, px, py, fs, exp_addr;
    bit pm;

    function automatic logic [11:0] tint_of(input logic [11:0] c);
        logic [11:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            s = int'((c >> (4*i)) & 12'hF) + int'((TINT >> (4*i)) & 12'hF);
            if (s > 15) s = 15;
            r[4*i +: 4] = 4'(s);
        end
        return r;
    endfunction

    task automatic model_reset();
        n = 0; px = 0; py = 0; pm = 0; fs = -1000000; exp_addr = 0;
        for (int i = 0; i < 3; i++) begin
            tim_a[i] = '0; bg_a[i] = '0; ins_a[i] = 0; addr_a[i] = 0;
            hit_a[i] = 0; vs_a[i] = 0; fa_a[i] = 0; hid_a[i] = 0;
        end
    endtask

    // One pixel clock: record inputs, advance the model, check outputs, step.
    task automatic tick();
        int k, hc, vc, rx;
        logic [11:0] exp_rgb, spr;
        logic [25:0] got_tim;
        k  = n + 2;
        hc = int'(u_in.hcount);
        vc = int'(u_in.vcount);
        tim_a[k] = {u_in.hcount, u_in.vcount, u_in.hsync, u_in.vsync, u_in.hblnk, u_in.vblnk};
        bg_a[k]  = u_in.rgb;
        hit_a[k] = hit;
        vs_a[k]  = u_in.vsync;
        ins_a[k] = hc >= px && hc < px + SPR_W && vc >= py && vc < py + SPR_H &&
                   !u_in.hblnk && !u_in.vblnk;
        rx = hc - px;
        addr_a[k] = ins_a[k] ? (vc - py) * SPR_W + (pm ? SPR_W - 1 - rx : rx) : 0;
        if (vs_a[k] && !vs_a[k-1]) begin
            px = int'(xpos); py = int'(ypos); pm = mirror;
        end
        if (hit_a[k] && !hit_a[k-1] && !fa_a[k]) fs = n + 1;
        fa_a[k+1]  = (n + 1 >= fs) && (n + 1 < fs + FT);
        hid_a[k+1] = fa_a[k+1] && BT > 0 && (((n + 1 - fs) / BT) % 2 == 1);

        @(negedge clk);
        if (ins_a[k-1]) exp_addr = addr_a[k-1];
        spr = rom[addr_a[k-2]];
        exp_rgb = bg_a[k-2];
        if (ins_a[k-2] && spr != KEY && !hid_a[k-1])
            exp_rgb = fa_a[k-1] ? tint_of(spr) : spr;
        got_tim = {u_out.hcount, u_out.vcount, u_out.hsync, u_out.vsync, u_out.hblnk, u_out.vblnk};

        n_chk++;
        assert (got_tim === tim_a[k-2])
        else begin n_fail++; $error("FAIL timing step %0d: got %h expected %h", n, got_tim, tim_a[k-2]); end
        n_chk++;
        assert (u_out.rgb === exp_rgb)
        else begin n_fail++; $error("FAIL rgb step %0d: got %h expected %h", n, u_out.rgb, exp_rgb); end
        n_chk++;
        assert (sprite_addr === ADDR_W'(exp_addr))
        else begin n_fail++; $error("FAIL addr step %0d: got %0d expected %0d", n, sprite_addr, exp_addr); end
        n_chk++;
        assert (flash_active === fa_a[k])
        else begin n_fail++; $error("FAIL flash_active step %0d: got %b expected %b", n, flash_active, fa_a[k]); end

        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic pix(input int hc, input int vc);
        u_in.hcount = 11'(hc); u_in.vcount = 11'(vc);
        u_in.hsync = 1'b0; u_in.vsync = 1'b0; u_in.hblnk = 1'b0; u_in.vblnk = 1'b0;
        u_in.rgb = 12'($urandom);
        tick();
    endtask

    task automatic vsync_pulse();
        for (int i = 0; i < 3; i++) begin
            u_in.hcount = 11'd0; u_in.vcount = 11'd0;
            u_in.hsync = 1'b0; u_in.vsync = (i < 2); u_in.hblnk = 1'b1; u_in.vblnk = 1'b1;
            u_in.rgb = 12'($urandom);
            tick();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        n_chk++;
        assert ({u_out.hcount, u_out.vcount, u_out.hsync, u_out.vsync, u_out.hblnk,
                 u_out.vblnk, u_out.rgb} === 38'd0)
        else begin n_fail++; $error("FAIL %s vga_out: got %h/%h/%h expected 0", tag, u_out.hcount, u_out.vcount, u_out.rgb); end
        n_chk++;
        assert (sprite_addr === '0)
        else begin n_fail++; $error("FAIL %s sprite_addr: got %0d expected 0", tag, sprite_addr); end
        n_chk++;
        assert (flash_active === 1'b0)
        else begin n_fail++; $error("FAIL %s flash_active: got %b expected 0", tag, flash_active); end
    endtask

    task automatic check_addr(input string tag, input int expv);
        n_chk++;
        assert (sprite_addr === ADDR_W'(expv))
        else begin n_fail++; $error("FAIL %s: got %0d expected %0d", tag, sprite_addr, expv); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 8; a++) rom[a] = 12'h300 + 12'(a);
        rom[2] = KEY;
        rom[5] = 12'h7F3;
        xpos = 11'd1; ypos = 11'd430; mirror = 1'b0; hit = 1'b0;
        u_in.hcount = '0; u_in.vcount = '0; u_in.hsync = 0; u_in.vsync = 0;
        u_in.hblnk = 0; u_in.vblnk = 0; u_in.rgb = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        model_reset();

        // Frame A: xpos=1, ypos=430, no mirror; mirror flips mid-frame
        vsync_pulse();
        for (int vc = 429; vc <= 432; vc++) begin
            if (vc == 431) mirror = 1'b1;
            for (int hc = 0; hc <= 6; hc++) begin
                pix(hc, vc);
                if (hc == 1 && vc == 430) check_addr("addr(1,430) plain", 0);
                if (hc == 4 && vc == 431) check_addr("addr(4,431) plain", 7);
            end
        end

        // Frame B: mirror now latched
        vsync_pulse();
        for (int hc = 0; hc <= 6; hc++) begin
            pix(hc, 430);
            if (hc == 1) check_addr("addr(1,430) mirror", 3);
            if (hc == 4) check_addr("addr(4,430) mirror", 0);
        end

        // Flash: 3-cycle hit pulse, a second edge mid-flash, tinted pixel
        hit = 1'b1; pix(0, 0); pix(0, 0); pix(0, 0);
        hit = 1'b0; pix(0, 0);
        hit = 1'b1; pix(0, 0);
        hit = 1'b0; pix(0, 0);
        pix(3, 431);
        pix(0, 0);
        n_chk++;
        assert (u_out.rgb === 12'hFF3)
        else begin n_fail++; $error("FAIL tint saturate: got %h expected ff3", u_out.rgb); end
        // hit held high across the end of the flash
        hit = 1'b1;
        for (int i = 0; i < 24; i++) pix(1 + (i % 4), 430 + (i / 4) % 2);
        hit = 1'b0;
        for (int i = 0; i < 4; i++) pix(1 + i, 431);

        // Randomised traffic around the sprite, including the x=2047 edge
        for (int i = 0; i < 800; i++) begin
            int xs [5];
            xs = '{0, 1, 3, 2045, 2046};
            xpos   = 11'(xs[$urandom_range(0, 4)]);
            ypos   = 11'(429 + $urandom_range(0, 1));
            mirror = 1'($urandom);
            if ($urandom_range(0, 5) == 0) hit = ~hit;
            u_in.hcount = 11'(($urandom_range(0, 1) ? 2040 : 0) + $urandom_range(0, 7));
            u_in.vcount = 11'(428 + $urandom_range(0, 5));
            u_in.hsync  = 1'($urandom);
            u_in.vsync  = ($urandom_range(0, 24) == 0);
            u_in.hblnk  = ($urandom_range(0, 7) == 0);
            u_in.vblnk  = ($urandom_range(0, 7) == 0);
            u_in.rgb    = 12'($urandom);
            tick();
        end

        // Reset in the middle of a flash and a line
        hit = 1'b0; pix(2, 430);
        hit = 1'b1; pix(2, 430); pix(3, 430); pix(2, 431);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid reset");
        @(posedge clk);
        #1;
        hit = 1'b0; xpos = 11'd2; ypos = 11'd430; mirror = 1'b0;
        rst_n = 1'b1;
        model_reset();
        vsync_pulse();
        for (int hc = 0; hc <= 7; hc++) pix(hc, 430);
        for (int hc = 0; hc <= 7; hc++) pix(hc, 431);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
